msrv32_lsu_rd: RTL
==================

Name: msrv32_lsu_rd

Overview:
- Parametrised sequential load unit that replaces the purely combinational load unit of the msrv32 core.
- Accepts a load request from the pipeline and issues one or two aligned bus reads; two reads are needed when the access crosses a bus-word boundary.
- Merges the returned bytes, then extracts and sign- or zero-extends the byte, half, word or dword.
- Returns the result with a one-cycle valid pulse and error flags. Sits between the execute stage and the AHB-style data port.

Parameters:
- XLEN, 32, data and address width; legal values are 32 or 64. Bus word is XLEN/8 bytes. OFS = log2(XLEN/8).
- ALLOW_MISALIGN, 1, 1 = misaligned loads are executed (split if needed); 0 = misaligned loads trap without any bus access.

Ports:
- clk_in  in  1  clock; all state changes on rising edge
- ms_riscv32_mp_rst_in  in  1  reset, asynchronous, active-high
- ld_valid_in  in  1  load request
- ld_ready_out  out  1  unit idle and able to accept a request
- ld_addr_in  in  XLEN  effective byte address
- ld_size_in  in  2  00 byte, 01 half, 10 word, 11 dword (when XLEN=32, 11 is treated as word)
- ld_unsigned_in  in  1  1 = zero-extend, 0 = sign-extend
- bus_req_out  out  1  address-phase request
- bus_addr_out  out  XLEN  bus-word-aligned address (low OFS bits are 0)
- bus_gnt_in  in  1  address phase accepted
- bus_rvalid_in  in  1  read data valid
- bus_rdata_in  in  XLEN  read data, little-endian
- bus_err_in  in  1  error response; qualified by bus_rvalid_in
- lu_valid_out  out  1  result valid, one-cycle pulse
- lu_output  out  XLEN  extended load result
- lu_err_out  out  1  bus error on this load (valid with lu_valid_out)
- lu_misalign_out  out  1  misaligned trap (valid with lu_valid_out)

Behaviour:
- Reset (async, immediate):
  - State goes to IDLE.
  - bus_req_out=0, bus_addr_out=0, lu_valid_out=0, lu_output=0, lu_err_out=0, lu_misalign_out=0.
  - Captured request registers are cleared.
  - After reset, ld_ready_out=1.
- Acceptance:
  - A request is accepted on a rising edge where ld_valid_in & ld_ready_out.
  - On acceptance, addr, size and unsigned are captured. Request inputs are ignored in all other cycles.
  - ld_ready_out = (state==IDLE).
- Derived values from the captured request:
  - nbytes = 1<<size (size 11 is treated as word when XLEN=32).
  - off = addr[OFS-1:0].
  - mis = (addr mod nbytes != 0).
  - split = (off + nbytes > XLEN/8).
- FSM states: IDLE, ADDR1, DATA1, ADDR2, DATA2, RESP.
  - IDLE: on accept, go to RESP if (mis & !ALLOW_MISALIGN), else go to ADDR1.
  - ADDR1:
    - bus_req_out=1, bus_addr_out = addr with low OFS bits cleared.
    - Both are held stable until bus_gnt_in, then go to DATA1.
  - DATA1:
    - bus_req_out=0. Wait for bus_rvalid_in, then capture bus_rdata_in as D1.
    - If bus_err_in, go to RESP with error; no second access is made.
    - Else if split, go to ADDR2; otherwise go to RESP.
  - ADDR2: as ADDR1, with address = aligned addr + XLEN/8 (wraps modulo 2^XLEN). Go to DATA2 on gnt.
  - DATA2: capture D2 on bus_rvalid_in; a bus_err_in here flags an error. Go to RESP.
  - RESP: one cycle, then IDLE. A new request can be accepted in the following IDLE cycle.
- bus_rvalid_in is ignored outside DATA1 and DATA2.
- Result, registered on entry to RESP:
  - Merge: m = {D2, D1} >> (off*8); D2 = 0 when not split.
  - Take the low nbytes of m and extend per unsigned.
  - When XLEN=32, size 10/11 is passed through with no extension.
  - When XLEN=64, a word is extended to 64 bits.
  - On error or misalign trap: lu_output=0 and the matching flag is set to 1.
- Outputs during and after RESP:
  - lu_valid_out=1 only in RESP; the flags are cleared on the next cycle.
  - lu_output holds its value until the next RESP or reset.
- Latency (accept edge = T, gnt and rvalid same-cycle):
  - Aligned or non-crossing load: lu_valid_out at T+3.
  - Split load: lu_valid_out at T+5.
  - Misaligned trap: lu_valid_out at T+1.
  - Each cycle of stalled gnt or rvalid adds one cycle.
- Reset mid-operation: the current load is abandoned and no lu_valid_out is produced. Late bus data arriving after reset is ignored.

Test Plan:
- XLEN=32, LB signed, addr 0x1003, rdata 0x80112233:
  - Expect bus_addr_out=0x1000.
  - Expect lu_output=0xFFFFFF80, lu_valid_out at T+3.
- LHU, addr 0x1002, rdata 0xBEEF1234: expect lu_output=0x0000BEEF.
- LH signed, same address and rdata: expect lu_output=0xFFFFBEEF.
- ALLOW_MISALIGN=1, LW, addr 0x2003:
  - Bus returns 0xAABBCCDD for 0x2000, then 0x11223344 for 0x2004.
  - Expect two bus_req phases and lu_output=0x223344AA at T+5.
- ALLOW_MISALIGN=0, LH, addr 0x1001: expect no bus_req_out, lu_misalign_out=1, lu_output=0, lu_valid_out at T+1.
- Split LW at 0x2003 with bus_err_in on the first beat:
  - Expect lu_err_out=1, lu_output=0.
  - Expect no ADDR2 request.
- Stall and reset behaviour:
  - Hold bus_gnt_in low for 3 cycles: bus_req_out and bus_addr_out stay stable.
  - Assert reset during DATA1: all outputs go to 0 immediately and no valid pulse follows.
  - ld_ready_out=1 after reset is released.
- XLEN=64, LWU, addr 0x104, rdata 0x89ABCDEF_01234567: expect lu_output=0x0000000089ABCDEF.

Source files
------------

// File: rtl/msrv32_lsu_rd_if.sv
// Bundle of the load-unit request, data-bus and result signals.
// The master modport is the load unit's view. The slave modport is the view of the
// pipeline and bus agent that surround the load unit.
interface msrv32_lsu_rd_if #(
  parameter int XLEN = 32
);
  logic            ld_valid_in;
  logic            ld_ready_out;
  logic [XLEN-1:0] ld_addr_in;
  logic [1:0]      ld_size_in;
  logic            ld_unsigned_in;
  logic            bus_req_out;
  logic [XLEN-1:0] bus_addr_out;
  logic            bus_gnt_in;
  logic            bus_rvalid_in;
  logic [XLEN-1:0] bus_rdata_in;
  logic            bus_err_in;
  logic            lu_valid_out;
  logic [XLEN-1:0] lu_output;
  logic            lu_err_out;
  logic            lu_misalign_out;

  modport master (
    input  ld_valid_in, ld_addr_in, ld_size_in, ld_unsigned_in,
    input  bus_gnt_in, bus_rvalid_in, bus_rdata_in, bus_err_in,
    output ld_ready_out, bus_req_out, bus_addr_out,
    output lu_valid_out, lu_output, lu_err_out, lu_misalign_out
  );

  modport slave (
    output ld_valid_in, ld_addr_in, ld_size_in, ld_unsigned_in,
    output bus_gnt_in, bus_rvalid_in, bus_rdata_in, bus_err_in,
    input  ld_ready_out, bus_req_out, bus_addr_out,
    input  lu_valid_out, lu_output, lu_err_out, lu_misalign_out
  );
endinterface

// File: rtl/msrv32_lsu_rd.sv
// Sequential load unit.
// Each load issues one or two aligned bus reads. A second read is issued when the
// access straddles a bus word. The unit merges the returned bytes, then
// sign- or zero-extends the selected byte, half, word or dword.
module msrv32_lsu_rd #(
  parameter int XLEN           = 32,
  parameter bit ALLOW_MISALIGN = 1'b1
) (
  input  logic             clk_in,
  input  logic             ms_riscv32_mp_rst_in,
  msrv32_lsu_rd_if.master  lsu
);
  localparam int BW  = XLEN / 8;
  localparam int OFS = $clog2(BW);
  localparam logic [XLEN-1:0] MASK_B = XLEN'(64'h0000_0000_0000_00FF);
  localparam logic [XLEN-1:0] MASK_H = XLEN'(64'h0000_0000_0000_FFFF);
  localparam logic [XLEN-1:0] MASK_W = XLEN'(64'h0000_0000_FFFF_FFFF);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR1 = 3'd1,
    DATA1 = 3'd2,
    ADDR2 = 3'd3,
    DATA2 = 3'd4,
    RESP  = 3'd5
  } state_t;

  // A dword request on a 32-bit core behaves as a word.
  function automatic logic [1:0] eff_size(input logic [1:0] sz);
    if ((XLEN == 32) && (sz == 2'b11)) return 2'b10;
    else return sz;
  endfunction

  function automatic logic [OFS+1:0] nbytes(input logic [1:0] sz);
    return (OFS+2)'(1) << eff_size(sz);
  endfunction

  function automatic logic is_mis(input logic [XLEN-1:0] a, input logic [1:0] sz);
    return |((OFS+2)'(a[OFS-1:0]) & (nbytes(sz) - (OFS+2)'(1)));
  endfunction

  function automatic logic is_split(input logic [XLEN-1:0] a, input logic [1:0] sz);
    return ((OFS+2)'(a[OFS-1:0]) + nbytes(sz)) > (OFS+2)'(BW);
  endfunction

  function automatic logic [XLEN-1:0] aligned(input logic [XLEN-1:0] a);
    return {a[XLEN-1:OFS], {OFS{1'b0}}};
  endfunction

  // Keep the low bytes and fill the upper bits with the sign bit, or with zero when unsigned.
  function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] m, input logic [1:0] sz,
                                             input logic uns);
    logic [XLEN-1:0] mask;
    logic            sgn;
    case (eff_size(sz))
      2'b00:   begin mask = MASK_B; sgn = m[7]  & ~uns; end
      2'b01:   begin mask = MASK_H; sgn = m[15] & ~uns; end
      2'b10:   begin mask = MASK_W; sgn = m[31] & ~uns; end
      default: begin mask = {XLEN{1'b1}}; sgn = 1'b0; end
    endcase
    return (m & mask) | ({XLEN{sgn}} & ~mask);
  endfunction

  state_t          state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [1:0]      size_q, size_d;
  logic            uns_q, uns_d;
  logic [XLEN-1:0] d1_q, d1_d;
  logic            bus_req_q, bus_req_d;
  logic [XLEN-1:0] bus_addr_q, bus_addr_d;
  logic            lu_valid_q, lu_valid_d;
  logic [XLEN-1:0] lu_out_q, lu_out_d;
  logic            lu_err_q, lu_err_d;
  logic            lu_mis_q, lu_mis_d;

  logic            accept_s;
  logic            split_s;
  logic [XLEN-1:0] lo_s, hi_s, merged_s;
  logic [OFS+2:0]  sh_s;

  assign accept_s = lsu.ld_valid_in & (state_q == IDLE);
  assign split_s  = is_split(addr_q, size_q);
  // Until the second beat arrives, the upper half of the merge window is zero.
  assign lo_s     = (state_q == DATA1) ? lsu.bus_rdata_in : d1_q;
  assign hi_s     = (state_q == DATA2) ? lsu.bus_rdata_in : {XLEN{1'b0}};
  assign sh_s     = {addr_q[OFS-1:0], 3'b000};
  assign merged_s = XLEN'({hi_s, lo_s} >> sh_s);

  // State register plus captured request, first beat and registered outputs.
  always_ff @(posedge clk_in or posedge ms_riscv32_mp_rst_in) begin
    if (ms_riscv32_mp_rst_in) begin
      state_q    <= IDLE;
      addr_q     <= {XLEN{1'b0}};
      size_q     <= 2'b00;
      uns_q      <= 1'b0;
      d1_q       <= {XLEN{1'b0}};
      bus_req_q  <= 1'b0;
      bus_addr_q <= {XLEN{1'b0}};
      lu_valid_q <= 1'b0;
      lu_out_q   <= {XLEN{1'b0}};
      lu_err_q   <= 1'b0;
      lu_mis_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      size_q     <= size_d;
      uns_q      <= uns_d;
      d1_q       <= d1_d;
      bus_req_q  <= bus_req_d;
      bus_addr_q <= bus_addr_d;
      lu_valid_q <= lu_valid_d;
      lu_out_q   <= lu_out_d;
      lu_err_q   <= lu_err_d;
      lu_mis_q   <= lu_mis_d;
    end
  end

  // Next-state logic: sequence the address and data phases of one or two beats.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          if (is_mis(lsu.ld_addr_in, lsu.ld_size_in) && !ALLOW_MISALIGN) state_d = RESP;
          else state_d = ADDR1;
        end else begin
          state_d = IDLE;
        end
      end
      ADDR1: begin
        if (lsu.bus_gnt_in) state_d = DATA1;
        else state_d = ADDR1;
      end
      DATA1: begin
        if (lsu.bus_rvalid_in) begin
          if (lsu.bus_err_in) state_d = RESP;
          else if (split_s) state_d = ADDR2;
          else state_d = RESP;
        end else begin
          state_d = DATA1;
        end
      end
      ADDR2: begin
        if (lsu.bus_gnt_in) state_d = DATA2;
        else state_d = ADDR2;
      end
      DATA2: begin
        if (lsu.bus_rvalid_in) state_d = RESP;
        else state_d = DATA2;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: request capture, bus address phase and the result computed on entry to RESP.
  always_comb begin
    addr_d     = addr_q;
    size_d     = size_q;
    uns_d      = uns_q;
    d1_d       = d1_q;
    bus_req_d  = (state_d == ADDR1) || (state_d == ADDR2);
    bus_addr_d = bus_addr_q;
    lu_valid_d = (state_d == RESP);
    lu_out_d   = lu_out_q;
    lu_err_d   = 1'b0;
    lu_mis_d   = 1'b0;
    if (accept_s) begin
      addr_d = lsu.ld_addr_in;
      size_d = lsu.ld_size_in;
      uns_d  = lsu.ld_unsigned_in;
    end else begin
      addr_d = addr_q;
    end
    if ((state_q == IDLE) && (state_d == ADDR1)) begin
      bus_addr_d = aligned(lsu.ld_addr_in);
    end else if ((state_q == DATA1) && (state_d == ADDR2)) begin
      bus_addr_d = aligned(addr_q) + XLEN'(BW);
    end else begin
      bus_addr_d = bus_addr_q;
    end
    if ((state_q == DATA1) && lsu.bus_rvalid_in) begin
      d1_d = lsu.bus_rdata_in;
    end else begin
      d1_d = d1_q;
    end
    if (state_d == RESP) begin
      case (state_q)
        IDLE: begin
          lu_out_d = {XLEN{1'b0}};
          lu_mis_d = 1'b1;
        end
        DATA1, DATA2: begin
          if (lsu.bus_err_in) begin
            lu_out_d = {XLEN{1'b0}};
            lu_err_d = 1'b1;
          end else begin
            lu_out_d = extend(merged_s, size_q, uns_q);
          end
        end
        default: lu_out_d = lu_out_q;
      endcase
    end else begin
      lu_out_d = lu_out_q;
    end
  end

  assign lsu.ld_ready_out    = (state_q == IDLE);
  assign lsu.bus_req_out     = bus_req_q;
  assign lsu.bus_addr_out    = bus_addr_q;
  assign lsu.lu_valid_out    = lu_valid_q;
  assign lsu.lu_output       = lu_out_q;
  assign lsu.lu_err_out      = lu_err_q;
  assign lsu.lu_misalign_out = lu_mis_q;
endmodule
